mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/sat_counter16.sv | 23 ++
 rtl/mem_access_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
//   state_t : controller FSM states
//   DATA_W  : address / data / counter width
//   CNT_MAX : saturation value of the performance counters
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at CNT_MAX.
//   clk   : clock
//   rst   : synchronous active-high clear
//   en    : increment request for this cycle
//   count : registered count value
module sat_counter16
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Issues one load/store per access
// to the memory system, freezes the pipeline while the access is outstanding
// or memory is busy, flags misaligned accesses, retires halt, and keeps
// saturating request/hit counters.
//   clk, rst                 : clock, synchronous active-high reset
//   DMemEn, DMemWrite        : EX/MEM access valid, 1=store
//   addr, wdata, halt_in     : EX/MEM address, store data, halt
//   mem_Rd, mem_Wr           : one-cycle request strobes
//   mem_Addr, mem_DataIn     : request address / write data
//   mem_DataOut, mem_Done    : memory read data, access complete
//   mem_Stall, mem_CacheHit  : memory busy, completing access hit
//   rdata                    : load result to MEM/WB
//   stall_pipe               : freeze IF..EX/MEM
//   mem_read_done/write_done : retire strobes
//   dcache_req, dcache_hit   : perf pulses
//   req_count, hit_count     : saturating counters
//   err, dump                : misaligned pulse, halt-retire pulse
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              DMemEn,
  input  logic              DMemWrite,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              halt_in,
  output logic              mem_Rd,
  output logic              mem_Wr,
  output logic [DATA_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_DataIn,
  input  logic [DATA_W-1:0] mem_DataOut,
  input  logic              mem_Done,
  input  logic              mem_Stall,
  input  logic              mem_CacheHit,
  output logic [DATA_W-1:0] rdata,
  output logic              stall_pipe,
  output logic              mem_read_done,
  output logic              mem_write_done,
  output logic              dcache_req,
  output logic              dcache_hit,
  output logic [DATA_W-1:0] req_count,
  output logic [DATA_W-1:0] hit_count,
  output logic              err,
  output logic              dump
);

  state_t            state;
  state_t            nextState;

  logic [DATA_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              writeQ;
  logic              haltQ;
  logic [DATA_W-1:0] rdataQ;
  logic              haltPending;

  logic              issue;
  logic              complete;
  logic              compWrite;
  logic              misaligned;
  logic              stallC;
  logic              dumpC;
  logic              latchEn;
  logic              haltSet;
  logic [DATA_W-1:0] addrC;
  logic [DATA_W-1:0] dataC;

  logic              reqInc;
  logic              hitInc;
  logic [DATA_W-1:0] reqCnt;
  logic [DATA_W-1:0] hitCnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    nextState  = state;
    issue      = 1'b0;
    complete   = 1'b0;
    compWrite  = writeQ;
    misaligned = 1'b0;
    stallC     = 1'b0;
    dumpC      = 1'b0;
    latchEn    = 1'b0;
    haltSet    = 1'b0;
    addrC      = addrQ;
    dataC      = wdataQ;

    case (state)
      IDLE: begin
        if (haltPending) begin
          // Halt that rode along with the previous access retires now
          dumpC     = 1'b1;
          nextState = HALTED;
        end else if (DMemEn) begin
          if (addr[0]) begin
            misaligned = 1'b1;
            haltSet    = halt_in;
          end else if (mem_Stall) begin
            stallC = 1'b1;
          end else begin
            issue     = 1'b1;
            latchEn   = 1'b1;
            addrC     = addr;
            dataC     = wdata;
            compWrite = DMemWrite;
            if (mem_Done) begin
              complete = 1'b1;
              haltSet  = halt_in;
            end else begin
              stallC    = 1'b1;
              nextState = WAIT;
            end
          end
        end else if (halt_in) begin
          dumpC     = 1'b1;
          nextState = HALTED;
        end
      end

      WAIT: begin
        if (mem_Done) begin
          complete  = 1'b1;
          haltSet   = haltQ;
          nextState = IDLE;
        end else begin
          stallC = 1'b1;
        end
      end

      HALTED: begin
        stallC = 1'b1;
      end

      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Access latches, load-result holding register and deferred halt
  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ       <= '0;
      wdataQ      <= '0;
      writeQ      <= 1'b0;
      haltQ       <= 1'b0;
      rdataQ      <= '0;
      haltPending <= 1'b0;
    end else begin
      if (latchEn) begin
        addrQ  <= addr;
        wdataQ <= wdata;
        writeQ <= DMemWrite;
        haltQ  <= halt_in;
      end
      if (complete) begin
        rdataQ <= mem_DataOut;
      end
      haltPending <= haltSet;
    end
  end

  // Same-cycle outputs; all forced to reset values while rst is high
  assign mem_Rd         = ~rst & issue & ~DMemWrite;
  assign mem_Wr         = ~rst & issue & DMemWrite;
  assign mem_Addr       = rst ? '0 : addrC;
  assign mem_DataIn     = rst ? '0 : dataC;
  assign rdata          = rst ? '0 : (complete ? mem_DataOut : rdataQ);
  assign stall_pipe     = ~rst & stallC;
  assign mem_read_done  = ~rst & complete & ~compWrite;
  assign mem_write_done = ~rst & complete & compWrite;
  assign dcache_req     = ~rst & issue;
  assign dcache_hit     = ~rst & complete & mem_CacheHit;
  assign err            = ~rst & misaligned;
  assign dump           = ~rst & dumpC;

  assign reqInc = dcache_req;
  assign hitInc = dcache_hit;

  sat_counter16 uReqCounter (
    .clk   (clk),
    .rst   (rst),
    .en    (reqInc),
    .count (reqCnt)
  );

  sat_counter16 uHitCounter (
    .clk   (clk),
    .rst   (rst),
    .en    (hitInc),
    .count (hitCnt)
  );

  assign req_count = rst ? '0 : reqCnt;
  assign hit_count = rst ? '0 : hitCnt;

endmodule
